// File: rtl/five_point_seven_serial_adder_4bit.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first.
// Operands are captured on start; sum/cout update only when all bits are processed.
module five_point_seven_serial_adder_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] psum_shift;

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    bit_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    bit_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    // New sum bit enters at the MSB so the first (LSB) bit ends at position 0.
    psum_shift            = psum_q >> 1;
    psum_shift[WIDTH-1]   = bit_s;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          psum_d  = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        carry_d = bit_c;
        psum_d  = psum_shift;
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = IDLE;
          sum_d   = psum_shift;
          cout_d  = bit_c;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_five_point_seven_serial_adder_4bit.sv
// Self-checking bench for the 4-bit serial adder: directed cases, random adds,
// busy/back-to-back handshakes and a mid-run asynchronous reset.
module tb_five_point_seven_serial_adder_4bit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
  logic         done;

  int tests = 0;
  int fails = 0;

  // Last completed result as the reference model sees it.
  logic [W-1:0] prev_sum  = '0;
  logic         prev_cout = 1'b0;
  logic [W:0]   exp_total;

  five_point_seven_serial_adder_4bit #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive operands with start at a negedge; returns at the negedge after capture.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
    a     = ta;
    b     = tb_;
    cin   = tc;
    start = 1'b1;
    exp_total = (W+1)'(int'(ta) + int'(tb_) + int'(tc));
    @(negedge clk);
    start = 1'b0;
  endtask

  // k = negedges already elapsed since the first negedge after capture.
  task automatic wait_done(input int k0);
    int k;
    k = k0;
    while (done !== 1'b1 && k < 20) begin
      chk("hold_sum", int'(sum), int'(prev_sum));
      chk("hold_cout", int'(cout), int'(prev_cout));
      @(negedge clk);
      k++;
    end
    chk("latency", k, W);
    chk("done", int'(done), 1);
    chk("busy_at_done", int'(busy), 0);
    chk("sum", int'(sum), int'(exp_total[W-1:0]));
    chk("cout", int'(cout), int'(exp_total[W]));
    $display("[TB] add a=%h b=%h cin=%0d -> sum=%h cout=%0d (exp %h/%0d)",
             a, b, cin, sum, cout, exp_total[W-1:0], exp_total[W]);
    prev_sum  = exp_total[W-1:0];
    prev_cout = exp_total[W];
  endtask

  task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
    launch(ta, tb_, tc);
    chk("busy_after_capture", int'(busy), 1);
    wait_done(0);
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;

    // Reset state
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_sum", int'(sum), 0);
    chk("rst_cout", int'(cout), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_hold_sum", int'(sum), 0);
      chk("idle_hold_busy", int'(busy), 0);
      chk("idle_hold_done", int'(done), 0);
    end

    // Directed cases
    run_add(4'b0001, 4'b0010, 1'b0); idle_check();
    run_add(4'b0101, 4'b0011, 1'b1); idle_check();
    run_add(4'b1010, 4'b0101, 1'b0); idle_check();
    run_add(4'b1111, 4'b1111, 1'b1); idle_check();
    run_add(4'b0000, 4'b0000, 1'b0); idle_check();

    // start while busy and operand changes mid-run are ignored
    launch(4'b0110, 4'b0111, 1'b1);
    @(negedge clk);
    start = 1'b1;
    a = 4'b1111; b = 4'b1111; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2);
    // back-to-back: start asserted in the done cycle
    run_add(4'b1001, 4'b1000, 1'b0);
    idle_check();

    // Random adds, alternating back-to-back and idle gaps
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      rc = 1'($urandom_range(0, 1));
      run_add(ra, rb, rc);
      if ($urandom_range(0, 1) == 1) idle_check();
    end

    // Non-zero result first so the reset clearing is visible
    run_add(4'b1100, 4'b0111, 1'b1);
    idle_check();
    launch(4'b0011, 4'b0100, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_sum", int'(sum), 0);
    chk("midrst_cout", int'(cout), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    prev_sum  = '0;
    prev_cout = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("no_done_after_rst", int'(done), 0);
      chk("no_busy_after_rst", int'(busy), 0);
    end
    run_add(4'b0111, 4'b1000, 1'b1);
    idle_check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
